// File: rtl/uart_rx.sv
// uart_rx: UART receiver, start + DATA_BIT (LSB first) + opt parity + STOP_BIT stops.
// Ports: i_clk, i_rst_n (async low), i_rxd in; o_data, o_valid pulse, o_parity_err, o_frame_err out.
module uart_rx #(
  parameter string CHECK_BIT = "None",
  parameter int    BPS       = 115200,
  parameter int    CLK       = 25_000_000,
  parameter int    DATA_BIT  = 8,
  parameter int    STOP_BIT  = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_rxd,
  output logic [DATA_BIT-1:0] o_data,
  output logic                o_valid,
  output logic                o_parity_err,
  output logic                o_frame_err
);

  localparam int BPS_CNT = CLK / BPS;
  localparam int HALF    = BPS_CNT / 2;
  localparam int CW      = $clog2(BPS_CNT) + 1;
  localparam int BMAX    = (DATA_BIT > STOP_BIT) ? DATA_BIT : STOP_BIT;
  localparam int BW      = $clog2(BMAX + 1);

  localparam logic [CW-1:0] TC_FULL = CW'(BPS_CNT - 1);
  localparam logic [CW-1:0] TC_HALF = CW'(HALF - 1);
  localparam logic [BW-1:0] LAST_D  = BW'(DATA_BIT - 1);
  localparam logic [BW-1:0] LAST_S  = BW'(STOP_BIT - 1);

  localparam bit USE_PAR = (CHECK_BIT != "None");
  localparam bit ODD     = (CHECK_BIT == "Odd");

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    CHECK,
    STOP
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [DATA_BIT-1:0] shr_q, shr_d;
  logic                perr_q, perr_d;
  logic                ferr_q, ferr_d;
  logic [DATA_BIT-1:0] data_q, data_d;
  logic                valid_q, valid_d;
  logic                perr_o_q, perr_o_d;
  logic                ferr_o_q, ferr_o_d;

  logic rxd_m_q, rxd_s_q, rxd_p_q;
  logic fall;
  logic tick;

  assign fall = rxd_p_q & ~rxd_s_q;
  assign tick = (cnt_q == TC_FULL);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shr_d    = shr_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    perr_o_d = perr_o_q;
    ferr_o_d = ferr_o_q;
    if (state_q != IDLE) cnt_d = cnt_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        bit_d  = '0;
        perr_d = 1'b0;
        ferr_d = 1'b0;
        // A level low line (break) never retriggers: an edge is needed.
        if (fall) state_d = START;
      end
      START: begin
        // Half-bit check; restarting the counter here puts every
        // later sample at a bit centre.
        if (cnt_q == TC_HALF) begin
          cnt_d   = '0;
          state_d = rxd_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick) begin
          cnt_d = '0;
          shr_d = {rxd_s_q, shr_q[DATA_BIT-1:1]};
          bit_d = bit_q + 1'b1;
          if (bit_q == LAST_D) begin
            bit_d   = '0;
            state_d = USE_PAR ? CHECK : STOP;
          end
        end
      end
      CHECK: begin
        if (tick) begin
          cnt_d   = '0;
          perr_d  = (^{shr_q, rxd_s_q}) ^ ODD;
          state_d = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          cnt_d  = '0;
          bit_d  = bit_q + 1'b1;
          ferr_d = ferr_q | ~rxd_s_q;
          // Leave at the last stop centre so a following start
          // edge is never missed.
          if (bit_q == LAST_S) begin
            state_d  = IDLE;
            valid_d  = 1'b1;
            data_d   = shr_q;
            perr_o_d = perr_q;
            ferr_o_d = ferr_q | ~rxd_s_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rxd_m_q  <= 1'b1;
      rxd_s_q  <= 1'b1;
      rxd_p_q  <= 1'b1;
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shr_q    <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      perr_o_q <= 1'b0;
      ferr_o_q <= 1'b0;
    end else begin
      rxd_m_q  <= i_rxd;
      rxd_s_q  <= rxd_m_q;
      rxd_p_q  <= rxd_s_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shr_q    <= shr_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      perr_o_q <= perr_o_d;
      ferr_o_q <= ferr_o_d;
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_parity_err = perr_o_q;
  assign o_frame_err  = ferr_o_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx across several configurations.
// Instances: 8N1, 8E1, 8O1, 6N2, 8N1@9600.
`timescale 1ns/1ps
module tb_uart_rx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rxd [5];
  int   cyc = 0;

  always #20 clk = ~clk;
  always @(posedge clk) cyc++;

  logic [7:0] d0, d1, d2, d4;
  logic [5:0] d3;
  logic v0, v1, v2, v3, v4;
  logic pe0, pe1, pe2, pe3, pe4;
  logic fe0, fe1, fe2, fe3, fe4;

  uart_rx u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rxd(rxd[0]),
    .o_data(d0), .o_valid(v0), .o_parity_err(pe0), .o_frame_err(fe0)
  );
  uart_rx #(.CHECK_BIT("Even")) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rxd(rxd[1]),
    .o_data(d1), .o_valid(v1), .o_parity_err(pe1), .o_frame_err(fe1)
  );
  uart_rx #(.CHECK_BIT("Odd")) u2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rxd(rxd[2]),
    .o_data(d2), .o_valid(v2), .o_parity_err(pe2), .o_frame_err(fe2)
  );
  uart_rx #(.DATA_BIT(6), .STOP_BIT(2)) u3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rxd(rxd[3]),
    .o_data(d3), .o_valid(v3), .o_parity_err(pe3), .o_frame_err(fe3)
  );
  uart_rx #(.BPS(9600)) u4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rxd(rxd[4]),
    .o_data(d4), .o_valid(v4), .o_parity_err(pe4), .o_frame_err(fe4)
  );

  int         checks = 0;
  int         failures = 0;
  int         vcnt [5];
  int         vcyc [5];
  int         t0 [5];
  logic       vperr [5];
  logic       vferr [5];
  logic [7:0] hist [5][16];

  task automatic rec(input int k, input logic v, input logic [7:0] d,
                     input logic pe, input logic fe);
    if (v) begin
      hist[k][vcnt[k] % 16] = d;
      vperr[k] = pe;
      vferr[k] = fe;
      vcyc[k]  = cyc;
      vcnt[k]++;
    end
  endtask

  always @(negedge clk) begin
    rec(0, v0, d0, pe0, fe0);
    rec(1, v1, d1, pe1, fe1);
    rec(2, v2, d2, pe2, fe2);
    rec(3, v3, {2'b00, d3}, pe3, fe3);
    rec(4, v4, d4, pe4, fe4);
  end

  function automatic logic [7:0] last(input int k);
    return hist[k][(vcnt[k] - 1) % 16];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // par < 0 means no parity bit; stopv holds the stop bit levels.
  task automatic send(input int k, input logic [7:0] d, input int db,
                      input int par, input int sb,
                      input logic [1:0] stopv, input int cpb);
    logic [15:0] f;
    int n;
    f = '0;
    n = 0;
    f[n] = 1'b0;
    n++;
    for (int i = 0; i < db; i++) begin
      f[n] = d[i];
      n++;
    end
    if (par >= 0) begin
      f[n] = par[0];
      n++;
    end
    for (int i = 0; i < sb; i++) begin
      f[n] = stopv[i];
      n++;
    end
    for (int i = 0; i < n; i++) begin
      rxd[k] = f[i];
      if (i == 0) t0[k] = cyc;
      repeat (cpb) @(negedge clk);
    end
    rxd[k] = 1'b1;
  endtask

  int b;
  int lat;
  logic [7:0] v55;

  initial begin
    for (int k = 0; k < 5; k++) begin
      rxd[k]  = 1'b1;
      vcnt[k] = 0;
      vcyc[k] = 0;
      t0[k]   = 0;
    end
    repeat (5) @(negedge clk);
    chk("rst_data", {24'd0, d0}, 32'h0);
    chk("rst_valid", {31'd0, v0}, 32'h0);
    chk("rst_perr", {31'd0, pe0}, 32'h0);
    chk("rst_ferr", {31'd0, fe0}, 32'h0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    b = vcnt[0];
    send(0, 8'hA5, 8, -1, 1, 2'b01, 217);
    repeat (10) @(negedge clk);
    chk("a5_count", vcnt[0] - b, 1);
    chk("a5_data", {24'd0, last(0)}, 32'hA5);
    chk("a5_perr", {31'd0, vperr[0]}, 32'h0);
    chk("a5_ferr", {31'd0, vferr[0]}, 32'h0);
    lat = vcyc[0] - t0[0];
    chk("a5_latency", {31'd0, (lat >= 2058 && lat <= 2065)}, 32'h1);

    b = vcnt[0];
    rxd[0] = 1'b0;
    repeat (50) @(negedge clk);
    rxd[0] = 1'b1;
    repeat (400) @(negedge clk);
    chk("glitch_count", vcnt[0] - b, 0);

    rxd[0] = 1'b0;
    repeat (20 * 217) @(negedge clk);
    chk("break_count", vcnt[0] - b, 1);
    chk("break_data", {24'd0, last(0)}, 32'h00);
    chk("break_ferr", {31'd0, vferr[0]}, 32'h1);
    rxd[0] = 1'b1;
    repeat (300) @(negedge clk);
    chk("break_after", vcnt[0] - b, 1);

    b = vcnt[0];
    send(0, 8'h00, 8, -1, 1, 2'b01, 217);
    send(0, 8'hFF, 8, -1, 1, 2'b01, 217);
    send(0, 8'h3C, 8, -1, 1, 2'b01, 217);
    repeat (10) @(negedge clk);
    chk("b2b_count", vcnt[0] - b, 3);
    chk("b2b_w0", {24'd0, hist[0][b % 16]}, 32'h00);
    chk("b2b_w1", {24'd0, hist[0][(b + 1) % 16]}, 32'hFF);
    chk("b2b_w2", {24'd0, hist[0][(b + 2) % 16]}, 32'h3C);
    chk("b2b_ferr", {31'd0, vferr[0]}, 32'h0);

    b = vcnt[0];
    v55 = 8'h55;
    rxd[0] = 1'b0;
    repeat (217) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd[0] = v55[i];
      repeat (217) @(negedge clk);
    end
    rxd[0] = v55[4];
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_data", {24'd0, d0}, 32'h0);
    chk("midrst_valid", {31'd0, v0}, 32'h0);
    chk("midrst_ferr", {31'd0, fe0}, 32'h0);
    rxd[0] = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (1500) @(negedge clk);
    chk("midrst_count", vcnt[0] - b, 0);
    send(0, 8'h55, 8, -1, 1, 2'b01, 217);
    repeat (10) @(negedge clk);
    chk("post_rst_count", vcnt[0] - b, 1);
    chk("post_rst_data", {24'd0, last(0)}, 32'h55);

    fork
      begin
        send(4, 8'hC3, 8, -1, 1, 2'b01, 2552);
        repeat (20) @(negedge clk);
        chk("slow_fast_data", {24'd0, last(4)}, 32'hC3);
        chk("slow_fast_ferr", {31'd0, vferr[4]}, 32'h0);
        send(4, 8'h5A, 8, -1, 1, 2'b01, 2656);
        repeat (20) @(negedge clk);
        chk("slow_slow_data", {24'd0, last(4)}, 32'h5A);
        chk("slow_slow_ferr", {31'd0, vferr[4]}, 32'h0);
        chk("slow_count", vcnt[4], 2);
      end
      begin
        send(1, 8'h07, 8, 1, 1, 2'b01, 217);
        repeat (10) @(negedge clk);
        chk("even_ok_perr", {31'd0, vperr[1]}, 32'h0);
        chk("even_ok_data", {24'd0, last(1)}, 32'h07);
        send(1, 8'h07, 8, 0, 1, 2'b01, 217);
        repeat (10) @(negedge clk);
        chk("even_bad_perr", {31'd0, vperr[1]}, 32'h1);
        chk("even_bad_data", {24'd0, last(1)}, 32'h07);
        send(2, 8'h07, 8, 0, 1, 2'b01, 217);
        repeat (10) @(negedge clk);
        chk("odd_ok_perr", {31'd0, vperr[2]}, 32'h0);
        send(2, 8'h07, 8, 1, 1, 2'b01, 217);
        repeat (10) @(negedge clk);
        chk("odd_bad_perr", {31'd0, vperr[2]}, 32'h1);
        chk("par_counts", vcnt[1] * 16 + vcnt[2], 2 * 16 + 2);
        send(3, 8'h2B, 6, -1, 2, 2'b11, 217);
        repeat (10) @(negedge clk);
        chk("d6_data", {24'd0, last(3)}, 32'h2B);
        chk("d6_ferr", {31'd0, vferr[3]}, 32'h0);
        send(3, 8'h2B, 6, -1, 2, 2'b01, 217);
        repeat (10) @(negedge clk);
        chk("d6_stop2_ferr", {31'd0, vferr[3]}, 32'h1);
        chk("d6_stop2_data", {24'd0, last(3)}, 32'h2B);
        chk("d6_count", vcnt[3], 2);
      end
    join

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
